// File: rtl/psum_row_accumulator_pkg.sv
// Shared constants, state encoding and row configuration for the psum row accumulator.
//   DATA_WIDTH  activation / output element width
//   PSUM_W      incoming signed PE partial-sum width
//   ACC_W       accumulator width (headroom for up to 4 passes)
//   KROWS       kernel-row passes per output row
//   COLS_L0/L1  psums per pass for layer 0 (sliding 3-tap) / layer 1 (stride 3)
package psum_row_accumulator_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned INPUT_SIZE = 28;
  localparam int unsigned PSUM_W     = 2 * DATA_WIDTH + 2;
  localparam int unsigned ACC_W      = PSUM_W + 2;
  localparam int unsigned KROWS      = 3;
  localparam int unsigned COLS_L0    = INPUT_SIZE - 2;
  localparam int unsigned COLS_L1    = 10;
  localparam int unsigned COL_W      = $clog2(COLS_L0);
  localparam int unsigned PASS_W     = $clog2(KROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Per-row configuration captured on an accepted start.
  typedef struct packed {
    logic                    relu_en;
    logic                    layer;
    logic signed [ACC_W-1:0] bias;
  } row_cfg_t;

  // Index of the final column for the selected layer.
  function automatic logic [COL_W-1:0] ncols_last(input logic layer_sel);
    return layer_sel ? COL_W'(COLS_L1 - 1) : COL_W'(COLS_L0 - 1);
  endfunction

endpackage

// File: rtl/psum_row_accumulator_postproc.sv
// psum_postproc: combinational output stage.
//   acc      signed accumulated row element (ACC_W)
//   bias     signed bias (ACC_W)
//   relu_en  clamp negative results to zero
//   res_c    signed saturated result (DATA_WIDTH)
// Computes sat((acc + bias) >>> SHIFT) with optional ReLU; shift floors toward -inf.
module psum_postproc
  import psum_row_accumulator_pkg::*;
#(
  parameter int unsigned IN_W  = ACC_W,
  parameter int unsigned OUT_W = DATA_WIDTH,
  parameter int unsigned SHIFT = 6
) (
  input  logic signed [IN_W-1:0]  acc,
  input  logic signed [IN_W-1:0]  bias,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] res_c
);

  // One extra bit so the bias add can never wrap.
  localparam int unsigned SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] shf_c;
  logic signed [SUM_W-1:0] rel_c;

  always_comb begin
    sum_c = SUM_W'(acc) + SUM_W'(bias);
    shf_c = sum_c >>> SHIFT;
    rel_c = (relu_en && (shf_c < 0)) ? '0 : shf_c;
    if (rel_c > SAT_MAX) begin
      res_c = SAT_MAX[OUT_W-1:0];
    end else if (rel_c < SAT_MIN) begin
      res_c = SAT_MIN[OUT_W-1:0];
    end else begin
      res_c = rel_c[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_row_accumulator.sv
// psum_row_accumulator: sums KROWS passes of per-column PE psums into a row buffer,
// then drains post-processed elements over a valid/ready stream.
//   clk, rst            clock, synchronous active-high reset
//   start               begin a row (IDLE only); latches layer, relu_en, bias
//   psum_valid/psum_in  incoming signed partial sums, one column per valid
//   out_valid/out_ready output handshake; out_data element, out_last on final element
//   busy                high outside IDLE
//   err_drop            sticky: psum seen outside ACCUM; cleared on accepted start
module psum_row_accumulator
  import psum_row_accumulator_pkg::*;
#(
  parameter int unsigned SHIFT = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         layer,
  input  logic                         relu_en,
  input  logic signed [ACC_W-1:0]      bias,
  input  logic                         psum_valid,
  input  logic signed [PSUM_W-1:0]     psum_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         err_drop
);

  state_e                  state_q, state_d;
  row_cfg_t                cfg_q;
  logic [COL_W-1:0]        col_cnt_q;
  logic [PASS_W-1:0]       pass_cnt_q;
  logic [COL_W-1:0]        rd_idx_q;
  logic signed [ACC_W-1:0] acc [COLS_L0];

  logic                    start_acc_c;
  logic                    acc_wr_c;
  logic                    col_wrap_c;
  logic                    pass_last_c;
  logic                    out_load_c;
  logic                    out_done_c;
  logic [COL_W-1:0]        last_col_c;
  logic signed [ACC_W-1:0] rd_val_c;
  logic signed [DATA_WIDTH-1:0] post_c;

  assign last_col_c = ncols_last(cfg_q.layer);
  assign rd_val_c   = acc[rd_idx_q];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d     = state_q;
    start_acc_c = 1'b0;
    acc_wr_c    = 1'b0;
    col_wrap_c  = 1'b0;
    pass_last_c = 1'b0;
    out_load_c  = 1'b0;
    out_done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc_c = 1'b1;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        if (psum_valid) begin
          acc_wr_c = 1'b1;
          if (col_cnt_q == last_col_c) begin
            col_wrap_c = 1'b1;
            if (pass_cnt_q == PASS_W'(KROWS - 1)) begin
              pass_last_c = 1'b1;
              state_d     = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        // The final element leaving ends the row; otherwise refill whenever the slot frees.
        if (out_valid && out_ready && out_last) begin
          out_done_c = 1'b1;
          state_d    = IDLE;
        end else if (!out_valid || out_ready) begin
          out_load_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Column / pass / read counters and latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q  <= '0;
      pass_cnt_q <= '0;
      rd_idx_q   <= '0;
      cfg_q      <= '0;
    end else begin
      if (start_acc_c) begin
        col_cnt_q  <= '0;
        pass_cnt_q <= '0;
        cfg_q      <= '{relu_en: relu_en, layer: layer, bias: bias};
      end else if (acc_wr_c) begin
        if (col_wrap_c) begin
          col_cnt_q <= '0;
          if (pass_last_c) begin
            rd_idx_q <= '0;
          end else begin
            pass_cnt_q <= pass_cnt_q + PASS_W'(1);
          end
        end else begin
          col_cnt_q <= col_cnt_q + COL_W'(1);
        end
      end
      // Hold on the last column so the read index never leaves the buffer.
      if (out_load_c && (rd_idx_q != last_col_c)) begin
        rd_idx_q <= rd_idx_q + COL_W'(1);
      end
    end
  end

  // Row buffer: first pass overwrites, later passes accumulate.
  always_ff @(posedge clk) begin
    if (acc_wr_c) begin
      acc[col_cnt_q] <= (pass_cnt_q == '0) ? ACC_W'(psum_in)
                                           : acc[col_cnt_q] + ACC_W'(psum_in);
    end
  end

  psum_postproc #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_WIDTH),
    .SHIFT (SHIFT)
  ) u_postproc (
    .acc     (rd_val_c),
    .bias    (cfg_q.bias),
    .relu_en (cfg_q.relu_en),
    .res_c   (post_c)
  );

  // Output register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      if (out_load_c) begin
        out_valid <= 1'b1;
        out_data  <= post_c;
        out_last  <= (rd_idx_q == last_col_c);
      end else if (out_done_c) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      busy <= (state_d != IDLE);
      // A stray psum wins over the clear so it is never silently lost.
      if (psum_valid && (state_q != ACCUM)) begin
        err_drop <= 1'b1;
      end else if (start_acc_c) begin
        err_drop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psum_row_accumulator.sv
// Directed bench: two instances (SHIFT=0 and SHIFT=6) share stimulus; a row-level
// model queues expected elements and one compare process checks every valid cycle.
module tb_psum_row_accumulator;
  import psum_row_accumulator_pkg::*;

  logic clk = 1'b0;
  logic rst, start, layer, relu_en, psum_valid, out_ready;
  logic signed [ACC_W-1:0]  bias;
  logic signed [PSUM_W-1:0] psum_in;

  logic ov0, ol0, busy0, err0, ov6, ol6, busy6, err6;
  logic signed [DATA_WIDTH-1:0] od0, od6;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int d0;
    int d6;
    bit last;
  } exp_t;
  exp_t eq[$];
  int   g0[$];
  int   g6[$];

  always #5 clk = ~clk;

  psum_row_accumulator #(.SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .layer(layer), .relu_en(relu_en), .bias(bias),
    .psum_valid(psum_valid), .psum_in(psum_in), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_last(ol0), .busy(busy0), .err_drop(err0));

  psum_row_accumulator #(.SHIFT(6)) u6 (
    .clk(clk), .rst(rst), .start(start), .layer(layer), .relu_en(relu_en), .bias(bias),
    .psum_valid(psum_valid), .psum_in(psum_in), .out_valid(ov6), .out_ready(out_ready),
    .out_data(od6), .out_last(ol6), .busy(busy6), .err_drop(err6));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Row element value from the plain arithmetic rules: floor shift, ReLU, clamp.
  function automatic int post_model(input int x, input int b, input bit relu, input int sh);
    int t;
    t = (x + b) >>> sh;
    if (relu && t < 0) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t;
  endfunction

  function automatic int at0(input int i);
    return (i < g0.size()) ? g0[i] : -9999;
  endfunction

  function automatic int at6(input int i);
    return (i < g6.size()) ? g6[i] : -9999;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle with out_valid, check both instances.
  bit stall_prev = 0;
  int prev_d0;
  bit prev_l0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (ov0 || ov6) begin
        chk("valid_match", int'(ov6), int'(ov0));
        if (eq.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("data_s0", int'(od0), eq[0].d0);
          chk("data_s6", int'(od6), eq[0].d6);
          chk("last_s0", int'(ol0), int'(eq[0].last));
          chk("last_s6", int'(ol6), int'(eq[0].last));
          if (out_ready) begin
            g0.push_back(int'(od0));
            g6.push_back(int'(od6));
            void'(eq.pop_front());
          end
        end
        if (stall_prev) begin
          chk("stall_data_hold", int'(od0), prev_d0);
          chk("stall_last_hold", int'(ol0), int'(prev_l0));
        end
      end else if (stall_prev) begin
        chk("stall_valid_hold", 0, 1);
      end
      stall_prev = ov0 && !out_ready;
      prev_d0    = int'(od0);
      prev_l0    = ol0;
    end
  end

  task automatic run_row(input bit lay, input bit relu, input int b, input int v,
                         input bit by_col, input bit gaps, input int stall_at,
                         input bit poke);
    int n = lay ? 10 : 26;
    int cyc = 0;
    bit stalled = 0;
    bit poked = 0;
    g0.delete();
    g6.delete();
    for (int c = 0; c < n; c++) begin
      int s;
      s = 3 * (by_col ? c : v);
      eq.push_back('{post_model(s, b, relu, 0), post_model(s, b, relu, 6), c == n - 1});
    end
    layer = lay; relu_en = relu; bias = ACC_W'(b);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("err_cleared_on_start", int'(err0), 0);
    chk("busy_in_accum", int'(busy0), 1);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < n; c++) begin
        if (p == 1 && c == 0) begin
          start = 1'b1;
          layer = ~lay;
        end
        psum_valid = 1'b1;
        psum_in    = PSUM_W'(by_col ? c : v);
        tick;
        start = 1'b0;
        layer = lay;
        if (p == 2 && c == n - 1) begin
          psum_valid = 1'b0;
          chk("latency_cycle1_idle", int'(ov0), 0);
          tick;
          chk("latency_cycle2_valid", int'(ov0), 1);
        end else if (gaps && (c % 4 == 1)) begin
          psum_valid = 1'b0;
          tick;
        end
      end
      psum_valid = 1'b0;
      if (gaps && p < 2) repeat (3) tick;
    end
    while (busy0 && cyc < 300) begin
      if (stall_at >= 0 && !stalled && ov0 && g0.size() == stall_at) begin
        stalled   = 1;
        out_ready = 1'b0;
        repeat (5) tick;
        out_ready = 1'b1;
      end else if (poke && !poked && ov0) begin
        poked      = 1;
        psum_valid = 1'b1;
        psum_in    = PSUM_W'(12345);
        tick;
        psum_valid = 1'b0;
        chk("err_drop_in_drain", int'(err0), 1);
      end else begin
        tick;
      end
      cyc++;
    end
    if (cyc >= 300) chk("drain_timeout", cyc, 0);
    chk("row_count_s0", g0.size(), n);
    chk("row_count_s6", g6.size(), n);
    chk("model_queue_empty", eq.size(), 0);
    chk("idle_out_valid", int'(ov0), 0);
    chk("idle_busy", int'(busy6), 0);
    eq.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; layer = 1'b0; relu_en = 1'b0; bias = '0;
    psum_valid = 1'b0; psum_in = '0; out_ready = 1'b1;

    // Pin the model on hand-computed values.
    chk("model_3", post_model(3, 0, 0, 0), 3);
    chk("model_sat_hi", post_model(30000, 0, 0, 6), 127);
    chk("model_relu", post_model(-300, 50, 1, 0), 0);
    chk("model_floor", post_model(-250, 0, 0, 6), -4);

    repeat (3) tick;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_out_last", int'(ol0), 0);
    chk("rst_out_data", int'(od0), 0);
    chk("rst_err_drop", int'(err0), 0);
    rst = 1'b0;
    tick;

    // Basic row of ones.
    run_row(0, 0, 0, 1, 0, 0, -1, 0);
    chk("ones_first", at0(0), 3);
    chk("ones_last", at0(25), 3);

    // Saturation both ways.
    run_row(0, 0, 0, 10000, 0, 0, -1, 0);
    chk("sat_hi_s6", at6(0), 127);
    run_row(0, 0, 0, -10000, 0, 0, -1, 0);
    chk("sat_lo_s0", at0(0), -128);

    // ReLU with bias, then same without ReLU.
    run_row(0, 1, 50, -100, 0, 0, -1, 0);
    chk("relu_clamp", at0(0), 0);
    run_row(0, 0, 50, -100, 0, 0, -1, 0);
    chk("no_relu_sat", at0(0), -128);
    chk("no_relu_s6", at6(0), -4);

    // Layer 1 with gaps and a 5-cycle stall at element 4.
    run_row(1, 0, 0, 0, 1, 1, 4, 0);
    chk("l1_elem4", at0(4), 12);
    chk("l1_elem9", at0(9), 27);

    // Stray psum in IDLE, then a clean row with a stray psum in DRAIN.
    psum_valid = 1'b1; psum_in = PSUM_W'(777);
    tick;
    psum_valid = 1'b0;
    chk("err_drop_idle", int'(err0), 1);
    chk("idle_stays_idle", int'(busy0), 0);
    run_row(0, 0, -7, 20, 0, 0, -1, 1);
    chk("after_err_row", at0(0), 53);

    // Reset in the middle of the second pass.
    layer = 1'b0; relu_en = 1'b0; bias = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 26; c++) begin
      psum_valid = 1'b1; psum_in = PSUM_W'(5);
      tick;
    end
    for (int c = 0; c < 13; c++) begin
      psum_valid = 1'b1; psum_in = PSUM_W'(5);
      tick;
    end
    psum_valid = 1'b1; rst = 1'b1;
    tick;
    rst = 1'b0; psum_valid = 1'b0;
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_out_valid", int'(ov0), 0);
    run_row(0, 0, 0, 2, 0, 0, -1, 0);
    chk("after_rst_first", at0(0), 6);
    chk("after_rst_last", at0(25), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_row_accumulator.md
Name: psum_row_accumulator

Overview:
- Downstream consumer of the PE's partial-sum stream.
- Accumulates per-column psums over KROWS kernel-row passes into a row buffer, then adds bias, applies arithmetic shift, optional ReLU and saturation.
- Drains the resulting DATA_WIDTH output row one element per valid/ready handshake to the feature-map writer.
- One instance per PE column group; layer selects column count (layer 0: sliding 3-tap, layer 1: stride-3).

Parameters:
- DATA_WIDTH, 8, activation/weight width (from parameters.v).
- PSUM_W, 2*DATA_WIDTH+2, width of incoming PE psum (signed).
- KROWS, 3, passes accumulated per output row.
- COLS_L0, INPUT_SIZE-2 (26), psums per pass in layer 0.
- COLS_L1, 10, psums per pass in layer 1 (stride 3 over the zero-padded row).
- SHIFT, 6, arithmetic right shift applied after bias add.
- ACC_W (localparam), PSUM_W+2, accumulator width; no overflow for KROWS<=4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin new output row; sampled only in IDLE.
- layer  in  1  0 → COLS_L0, 1 → COLS_L1; latched on accepted start.
- relu_en  in  1  enable ReLU; latched on accepted start.
- bias  in  ACC_W  signed bias; latched on accepted start.
- psum_valid  in  1  psum_in valid this cycle (driven by PE flag_comp).
- psum_in  in  PSUM_W  signed partial sum.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  signed result element.
- out_last  out  1  high with final element of row.
- busy  out  1  high in any state except IDLE.
- err_drop  out  1  sticky; psum_valid seen outside ACCUM; cleared on accepted start.

Behaviour:
- Reset: state=IDLE; out_valid, out_data, out_last, busy, err_drop = 0; counters cleared; buffer contents don't care.
- Internal: acc[0..COLS_L0-1] of ACC_W bits; col_cnt; pass_cnt; rd_idx; ncols = layer_q ? COLS_L1 : COLS_L0.
- IDLE:
  - On start: latch layer/relu_en/bias, clear err_drop, col_cnt=pass_cnt=0 → ACCUM.
  - psum_valid in IDLE sets err_drop; data is dropped.
- ACCUM, per psum_valid cycle:
  - acc[col_cnt] <= (pass_cnt==0) ? sext(psum_in) : acc[col_cnt]+sext(psum_in); col_cnt++.
  - If col_cnt==ncols-1: col_cnt=0. If pass_cnt==KROWS-1, go to DRAIN with rd_idx=0; otherwise pass_cnt++.
  - Gaps between valids and between passes are allowed, of any length.
- DRAIN:
  - Output register loads post(acc[rd_idx]), rd_idx++, whenever out_valid==0 or (out_valid && out_ready).
  - First out_valid asserts 1 cycle after entering DRAIN.
  - out_data, out_valid and out_last must hold stable while out_valid && !out_ready.
  - out_last=1 with element ncols-1.
  - When the last element handshakes: out_valid=0 next cycle → IDLE.
  - Full throughput: one element per cycle when out_ready is held high.
- post(x): t = (x + bias_q) >>> SHIFT (floor); if relu_en and t<0 then t=0; saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- psum_valid in DRAIN sets err_drop; data is dropped and the buffer is unchanged.
- start while busy is ignored.
- Reset mid-operation returns to the reset state next cycle; partial row is discarded.
- Latency: last psum of final pass → first out_valid = 2 cycles.

Decomposition:
- Shared in parameters.v: DATA_WIDTH, INPUT_SIZE, PSUM_W, KROWS, COLS_L0, COLS_L1, state encodings (IDLE=0, ACCUM=1, DRAIN=2).
- Sub-module psum_postproc: combinational bias add, shift, ReLU, saturate (ACC_W in, DATA_WIDTH out). Reused by future output-stage blocks.

Test Plan:
- Layer 0, bias=0, SHIFT=0, relu_en=0, 3 passes of psum_in=1 × 26 cols → 26 outputs each 3; out_last on 26th only; then IDLE, busy=0.
- Layer 0, psum_in=10000 each pass, SHIFT=6 → (30000>>6)=468 saturates to 127. Psum_in=-10000 → -128.
- relu_en=1, psum_in=-100, bias=50, SHIFT=0 → -250 clamps to 0. Same with relu_en=0 → -128.
- Layer 1, out_ready low for 5 cycles at element 4, psum_in=col index per pass, SHIFT=0 → outputs 0,3,...,27 in order; element 4 (=12) held stable during the stall; exactly 10 outputs.
- psum_valid pulse in IDLE → err_drop=1, buffer unaffected. Next start → err_drop=0 and a correct row.
- rst asserted mid pass 1 (col 13) → next cycle busy=0, out_valid=0. A new start with 3 full passes of 2 → all outputs 6.
